// File: rtl/duty_cycle_pkg.sv
// Shared widths and types for the duty-cycle measurement block.
package duty_cycle_pkg;
    localparam int VALUE_W            = 17;
    localparam int DEFAULT_WINDOW_LEN = 65536;

    typedef logic [VALUE_W-1:0] duty_value_t;
endpackage

// File: rtl/duty_cycle_circuit_sync_ff.sv
// N-stage single-bit synchroniser; the last stage is the only safe output.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/duty_cycle_circuit.sv
// Counts synchronised high cycles of ring_in over fixed windows of WINDOW_LEN clk cycles.
module duty_cycle_circuit
    import duty_cycle_pkg::*;
#(
    parameter int WINDOW_LEN  = DEFAULT_WINDOW_LEN,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ring_in,
    input  logic               enable,
    output logic [VALUE_W-1:0] value
);
    localparam duty_value_t LAST = duty_value_t'(WINDOW_LEN - 1);

    logic        s;
    duty_value_t win_cnt;
    duty_value_t hi_cnt;
    duty_value_t hi_next;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ring_in),
        .q     (s)
    );

    // Count includes the current cycle's sample, so the final cycle is not lost.
    assign hi_next = hi_cnt + duty_value_t'(s);

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt <= '0;
            hi_cnt  <= '0;
            value   <= '0;
        end else if (!enable) begin
            win_cnt <= '0;
            hi_cnt  <= '0;
        end else if (win_cnt == LAST) begin
            value   <= hi_next;
            win_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            hi_cnt  <= hi_next;
        end
    end
endmodule

// File: tb/tb_duty_cycle_circuit.sv
// Scoreboard bench: stimulus queues expected values per edge, a monitor compares them.
module tb_duty_cycle_circuit;
    logic        clk = 1'b0;
    logic        reset_a, enable_a, ring_a;
    logic        reset_b, enable_b, ring_b;
    logic [16:0] value_a, value_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int dut;
        int exp;
        int tag;
    } exp_t;
    exp_t q[$];

    duty_cycle_circuit #(.WINDOW_LEN(16), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(reset_a), .ring_in(ring_a), .enable(enable_a), .value(value_a)
    );
    duty_cycle_circuit #(.WINDOW_LEN(1), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .reset(reset_b), .ring_in(ring_b), .enable(enable_b), .value(value_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_at(int dut, int c, int v, int tag);
        exp_t e;
        e.cyc = c; e.dut = dut; e.exp = v; e.tag = tag;
        q.push_back(e);
    endfunction

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every queued expectation scheduled for the edge just taken.
    initial forever begin
        @(negedge clk);
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            int   got;
            e   = q.pop_front();
            got = (e.dut == 0) ? int'(value_a) : int'(value_b);
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL scen%0d dut%0d: expectation for edge %0d checked late at edge %0d", e.tag, e.dut, e.cyc, cyc);
            end else if (got != e.exp) begin
                errors++;
                $display("FAIL scen%0d dut%0d edge %0d: value got %0d expected %0d", e.tag, e.dut, e.cyc, got, e.exp);
            end
        end
    end

    initial begin
        int e;
        int c0;
        reset_a = 1; enable_a = 0; ring_a = 0;
        reset_b = 1; enable_b = 0; ring_b = 0;
        tick(3);
        expect_at(0, cyc, 0, 0);
        expect_at(1, cyc, 0, 0);
        reset_a = 0; reset_b = 0;

        // 1: constant high, two windows
        ring_a = 1;
        tick(3);
        enable_a = 1; e = cyc;
        expect_at(0, e + 15, 0, 1);
        expect_at(0, e + 16, 16, 1);
        expect_at(0, e + 31, 16, 1);
        expect_at(0, e + 32, 16, 1);
        tick(32);

        // 2: constant low after a full-scale result
        enable_a = 0; ring_a = 0;
        tick(3);
        expect_at(0, cyc, 16, 2);
        enable_a = 1; e = cyc;
        expect_at(0, e + 15, 16, 2);
        expect_at(0, e + 16, 0, 2);
        tick(16);
        enable_a = 0;

        // 3: periodic waves, 4/16 then 8/16
        c0 = cyc;
        for (int i = 0; i < 68; i++) begin
            ring_a   = ((i % 16) < 4);
            enable_a = (i >= 20);
            if (i == 20) begin
                expect_at(0, c0 + 36, 4, 3);
                expect_at(0, c0 + 52, 4, 3);
                expect_at(0, c0 + 68, 4, 3);
            end
            tick();
        end
        enable_a = 0;
        c0 = cyc;
        for (int i = 0; i < 52; i++) begin
            ring_a   = ((i % 16) < 8);
            enable_a = (i >= 20);
            if (i == 20) begin
                expect_at(0, c0 + 35, 4, 3);
                expect_at(0, c0 + 36, 8, 3);
                expect_at(0, c0 + 52, 8, 3);
            end
            tick();
        end
        enable_a = 0;

        // 4: enable dropped mid-window discards the partial count
        ring_a = 1;
        tick(3);
        enable_a = 1; e = cyc;
        expect_at(0, e + 16, 16, 4);
        tick(25);
        enable_a = 0; ring_a = 0;
        tick(5);
        expect_at(0, cyc, 16, 4);
        enable_a = 1; e = cyc;
        expect_at(0, e + 7, 16, 4);
        expect_at(0, e + 15, 16, 4);
        expect_at(0, e + 16, 0, 4);
        tick(16);
        enable_a = 0;

        // 5: reset mid-window clears value and synchroniser
        ring_a = 1;
        tick(3);
        enable_a = 1; e = cyc;
        expect_at(0, e + 16, 16, 5);
        tick(21);
        reset_a = 1;
        expect_at(0, e + 22, 0, 5);
        tick();
        reset_a = 0;
        expect_at(0, e + 37, 0, 5);
        expect_at(0, e + 38, 14, 5);
        tick(16);
        enable_a = 0;

        // 6: single-cycle window tracks ring_in three edges late
        enable_b = 1;
        c0 = cyc;
        for (int i = 0; i < 24; i++) begin
            ring_b = ((i / 3) % 2 == 1);
            expect_at(1, c0 + i + 3, int'(ring_b), 6);
            tick();
        end
        tick(3);

        begin
            int guard = 0;
            while (q.size() > 0 && guard < 100) begin
                tick();
                guard++;
            end
            if (q.size() > 0) begin
                errors++;
                $display("FAIL drain: %0d expectations pending, required 0", q.size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
